pc_gen: RTL
===========

Name: pc_gen

Overview:
- Program-counter generator. Sits directly upstream of the instruction-fetch stage and drives the fetch address `pc` every cycle.
- Selects the next PC from four sources, highest priority first: trap entry, EX-stage redirect (branch/jump resolution), optional static prediction, sequential +4.
- Absorbs fetch stalls. Captures any redirect that arrives while fetch is stalled and applies it once the stall releases.
- Emits a flush pulse so that downstream stages squash the wrong-path instruction.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC used when a redirect or trap target is misaligned.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- if_stall  in  1  fetch stall; 1 = hold pc.
- redirect_valid  in  1  EX-stage branch/jump resolved to a non-sequential target (single-cycle pulse).
- redirect_target  in  32  target address for redirect_valid.
- trap_valid  in  1  trap/exception entry request (single-cycle pulse).
- trap_target  in  32  handler address for trap_valid.
- if_pc  in  32  PC of the instruction currently held by fetch.
- if_instr  in  32  instruction currently held by fetch (used only with the optional feature).
- pc  out  32  registered fetch address presented to fetch/imem.
- flush  out  1  registered pulse: instruction fetch captures this cycle is wrong-path; downstream replaces it with NOP.
- misalign_err  out  1  registered pulse: the applied target had bits[1:0] != 0.
- pred_taken  out  1  combinational: if_instr predicted taken (tied 0 without the optional feature).

Behaviour:
- Reset (rst=1 at posedge) → state BOOT; all outputs and internal registers take these values:
  - pc = RESET_VECTOR.
  - flush = 0, misalign_err = 0.
  - pend_valid = 0, pend_target = 0.
  - rst has priority over every other input. Any pending redirect is discarded.
- States: BOOT, RUN, HOLD.
- BOOT:
  - Lasts exactly one cycle; pc holds RESET_VECTOR.
  - Next state is RUN regardless of if_stall.
  - A trap/redirect arriving in BOOT is latched into pend and the state goes to HOLD instead.
- RUN, if_stall=0, next pc by priority:
  - trap_valid → trap_target.
  - else redirect_valid → redirect_target.
  - else prediction (optional feature).
  - else pc+4, with 32-bit wrap: 32'hFFFF_FFFC + 4 = 0.
  - Any non-sequential selection asserts flush=1 for exactly the next cycle.
- RUN, if_stall=1:
  - pc holds.
  - If trap_valid or redirect_valid is high: latch the higher-priority target into pend_target, set pend_valid=1, go to HOLD.
- HOLD:
  - pc holds while if_stall=1.
  - A newer trap/redirect overwrites pend_target; the latest event wins, with trap beating redirect within the same cycle.
  - On the first cycle with if_stall=0: pc <= pend_target (or the same-cycle trap/redirect if present, which takes priority), flush=1 next cycle, pend_valid <= 0, go to RUN.
- Misalignment: if the selected non-sequential target has [1:0] != 0, pc <= TRAP_VECTOR, misalign_err=1 for one cycle, flush=1.
- Latency: redirect → new pc is 1 cycle when unstalled, or 1 cycle after the stall drops.
- flush and misalign_err are never high for two consecutive cycles unless a new event occurs.

Optional Feature:
- Macro: PCGEN_BTFN_EN (static backward-taken/forward-not-taken prediction).
- With the macro defined, in RUN with if_stall=0, no trap and no redirect:
  - if_instr[6:0]=7'b1100011 (branch) with if_instr[31]=1 → pred_taken=1; pc <= if_pc + sign-extended B-imm; flush=1.
  - if_instr[6:0]=7'b1101111 (JAL) → pred_taken=1; pc <= if_pc + sign-extended J-imm; flush=1.
  - Misprediction recovery uses the normal redirect path.
- Without the macro: pred_taken=0, and no dependence on if_instr or if_pc.

Decomposition:
- Shared package:
  - state enum (BOOT/RUN/HOLD).
  - opcode constants OPC_BRANCH=7'b1100011, OPC_JAL=7'b1101111.
  - NOP encoding 32'h0000_0013.
  - Reset/trap vector defaults.
- One sub-module, pcgen_btfn_pred: combinational immediate decode and target adder, instantiated only under PCGEN_BTFN_EN.

Test Plan:
- Reset then 4 free cycles → pc: 0x0 (BOOT), 0x0, 0x4, 0x8; flush=0 throughout.
- pc=0x10, redirect_valid=1, target=0x200 → next pc=0x200, flush=1 one cycle, then 0x204.
- if_stall=1 at pc=0x20; redirect to 0x300 during the stall, then redirect to 0x400 two cycles later; release stall → pc holds 0x20 during the stall, then 0x400, flush=1.
- trap_valid (0x100) and redirect_valid (0x80) in the same cycle → pc=0x100; redirect to 0x202 → pc=TRAP_VECTOR, misalign_err=1.
- pc=0xFFFF_FFFC, no events → next pc=0x0.
- With PCGEN_BTFN_EN: if_pc=0x40, if_instr=0xFE000EE3 (beq x0,x0,-4) → pred_taken=1, next pc=0x3C; forward branch (if_instr[31]=0) → sequential.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the program-counter generator.
// Optional static prediction is enabled with the PCGEN_BTFN_EN macro.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } pc_state_e;

  localparam logic [6:0]  OPC_BRANCH       = 7'b1100011;
  localparam logic [6:0]  OPC_JAL          = 7'b1101111;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pcgen_btfn_pred.sv
// Static backward-taken/forward-not-taken predictor: decodes B/J immediates
// and forms the predicted target relative to the fetched instruction's PC.
import pc_gen_pkg::*;

module pcgen_btfn_pred (
  input  logic [31:0] if_pc,
  input  logic [31:0] if_instr,
  output logic        taken,
  output logic [31:0] target
);

  logic [31:0] b_imm;
  logic [31:0] j_imm;
  logic        is_branch;
  logic        is_jal;

  assign b_imm = {{20{if_instr[31]}}, if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
  assign j_imm = {{12{if_instr[31]}}, if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};

  assign is_branch = (if_instr[6:0] == OPC_BRANCH);
  assign is_jal    = (if_instr[6:0] == OPC_JAL);

  // Only backward branches (negative offset) are predicted taken; JAL always is.
  always_comb begin
    taken  = 1'b0;
    target = if_pc;
    if (is_jal) begin
      taken  = 1'b1;
      target = if_pc + j_imm;
    end else if (is_branch && if_instr[31]) begin
      taken  = 1'b1;
      target = if_pc + b_imm;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: trap > redirect > prediction > pc+4, with stall
// absorption of redirects. Define PCGEN_BTFN_EN for static BTFN prediction.
import pc_gen_pkg::*;

module pc_gen #(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] TRAP_VECTOR  = DEF_TRAP_VECTOR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        trap_valid,
  input  logic [31:0] trap_target,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_instr,
  output logic [31:0] pc,
  output logic        flush,
  output logic        misalign_err,
  output logic        pred_taken
);

  pc_state_e   state, state_next;
  logic [31:0] pc_next;
  logic        flush_next;
  logic        misalign_next;
  logic        pend_valid, pend_valid_next;
  logic [31:0] pend_target, pend_target_next;

  logic        event_valid;
  logic [31:0] event_target;
  logic        take_jump;
  logic [31:0] jump_target;
  logic        pred_hit;
  logic [31:0] pred_target;

`ifdef PCGEN_BTFN_EN
  pcgen_btfn_pred u_pred (
    .if_pc   (if_pc),
    .if_instr(if_instr),
    .taken   (pred_hit),
    .target  (pred_target)
  );
`else
  logic unused_fetch;
  assign unused_fetch = ^{if_pc, if_instr};
  assign pred_hit     = 1'b0;
  assign pred_target  = 32'h0000_0000;
`endif

  assign event_valid  = trap_valid | redirect_valid;
  assign event_target = trap_valid ? trap_target : redirect_target;

  always_comb begin
    state_next       = state;
    pc_next          = pc;
    flush_next       = 1'b0;
    misalign_next    = 1'b0;
    pend_valid_next  = pend_valid;
    pend_target_next = pend_target;
    take_jump        = 1'b0;
    jump_target      = pc;
    pred_taken       = 1'b0;

    case (state)
      BOOT: begin
        if (event_valid) begin
          pend_valid_next  = 1'b1;
          pend_target_next = event_target;
          state_next       = HOLD;
        end else begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (if_stall) begin
          if (event_valid) begin
            pend_valid_next  = 1'b1;
            pend_target_next = event_target;
            state_next       = HOLD;
          end
        end else if (event_valid) begin
          take_jump   = 1'b1;
          jump_target = event_target;
        end else if (pred_hit) begin
          take_jump   = 1'b1;
          jump_target = pred_target;
          pred_taken  = 1'b1;
        end else begin
          pc_next = pc + 32'd4;
        end
      end
      HOLD: begin
        // Latest event wins while stalled; a same-cycle event beats the pending one on release.
        if (if_stall) begin
          if (event_valid) begin
            pend_target_next = event_target;
          end
        end else begin
          take_jump       = 1'b1;
          jump_target     = event_valid ? event_target : pend_target;
          pend_valid_next = 1'b0;
          state_next      = RUN;
        end
      end
      default: state_next = BOOT;
    endcase

    if (take_jump) begin
      flush_next = 1'b1;
      if (is_misaligned(jump_target)) begin
        pc_next       = TRAP_VECTOR;
        misalign_next = 1'b1;
      end else begin
        pc_next = jump_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= BOOT;
      pc           <= RESET_VECTOR;
      flush        <= 1'b0;
      misalign_err <= 1'b0;
      pend_valid   <= 1'b0;
      pend_target  <= 32'h0000_0000;
    end else begin
      state        <= state_next;
      pc           <= pc_next;
      flush        <= flush_next;
      misalign_err <= misalign_next;
      pend_valid   <= pend_valid_next;
      pend_target  <= pend_target_next;
    end
  end

endmodule
